// File: rtl/uart_arb_pkg.sv
// ---------------------------------------------------------------------------
// uart_arb_pkg
// Shared definitions for the round-robin UART transmit arbiter:
//   - arb_state_e : arbiter FSM states (tag states are used only when the
//                   UART_ARB_TAG_EN macro is defined)
//   - TAG_BASE    : ASCII '0', added to the winner index to form the tag byte
//   - DEF_*       : default timing for a 100 MHz clock at 9600 baud
// ---------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT      = 3'd2,
        ST_START_TAG = 3'd3,
        ST_WAIT_TAG  = 3'd4
    } arb_state_e;

    localparam logic [7:0] TAG_BASE = 8'h30;

    localparam int DEF_BAUD_DIV    = 10416;
    localparam int DEF_FRAME_BAUDS = 12;

endpackage

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin selector. It finds the first asserted request at
// or after rr_ptr_i, wrapping around.
// Ports:
//   req_i        [NUM_REQ-1:0]  request levels
//   rr_ptr_i     [PW-1:0]       highest-priority index for this decision
//   winner_o     [NUM_REQ-1:0]  one-hot winner (all zero when no request)
//   winner_idx_o [PW-1:0]       binary index of the winner
//   valid_o                     at least one request is asserted
// ---------------------------------------------------------------------------
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      rr_ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [PW-1:0]      winner_idx_o,
    output logic               valid_o
);

    int cand;

    // The scan runs from the farthest position back to rr_ptr_i. The last
    // hit is therefore the nearest request in wrap-around order.
    always_comb begin
        valid_o      = 1'b0;
        winner_idx_o = '0;
        cand         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_i[cand]) begin
                valid_o      = 1'b1;
                winner_idx_o = PW'(cand);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign winner_o[gi] = valid_o && (winner_idx_o == PW'(gi));
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART byte transmitter between NUM_REQ requesters with
// round-robin arbitration. The transmitter reports neither busy nor done, so
// this block times each frame itself. It holds tx_start for BAUD_DIV cycles,
// which covers at least one baud tick. It then waits FRAME_BAUDS baud periods
// before the next arbitration.
// Optional feature: when the UART_ARB_TAG_EN macro is defined, each grant
// sends two frames. The first is the tag byte ('0' + winner index) and the
// second is the data byte.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   req      [N-1:0]   byte-pending levels, held by requesters until ack
//   req_data [8N-1:0]  byte of requester i at [8*i+7:8*i]
//   ack      [N-1:0]   one-cycle one-hot pulse when a byte is latched
//   grant    [N-1:0]   one-hot owner of the frame in progress
//   busy               high whenever the arbiter is not idle
//   tx_start           transmitter start strobe
//   tx_data  [7:0]     transmitter data byte
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BAUD_DIV    = DEF_BAUD_DIV,
    parameter int FRAME_BAUDS = DEF_FRAME_BAUDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int TW = $clog2(FRAME_BAUDS * BAUD_DIV + 1);

    localparam logic [TW-1:0] START_LAST = TW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(FRAME_BAUDS * BAUD_DIV - 1);

    arb_state_e           state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [7:0]           tx_data_q, tx_data_d;
`ifdef UART_ARB_TAG_EN
    logic [7:0]           data_q, data_d;
`endif

    logic [NUM_REQ-1:0]   pick_winner;
    logic [PW-1:0]        pick_idx;
    logic                 pick_valid;
    logic [7:0]           req_bytes [NUM_REQ];
    logic [7:0]           pick_byte;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = req_data[8*gi +: 8];
    end

    assign pick_byte = req_bytes[pick_idx];

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i        (req),
        .rr_ptr_i     (rr_ptr_q),
        .winner_o     (pick_winner),
        .winner_idx_o (pick_idx),
        .valid_o      (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        ack_d      = '0;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
`ifdef UART_ARB_TAG_EN
        data_d     = data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d    = pick_winner;
                    ack_d      = pick_winner;
                    rr_ptr_d   = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + PW'(1);
                    timer_d    = '0;
                    tx_start_d = 1'b1;
`ifdef UART_ARB_TAG_EN
                    // The tag goes out first. The data byte waits in data_q.
                    tx_data_d  = TAG_BASE + 8'(pick_idx);
                    data_d     = pick_byte;
                    state_d    = ST_START_TAG;
`else
                    tx_data_d  = pick_byte;
                    state_d    = ST_START;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_START_TAG: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == START_LAST) begin
                    timer_d    = '0;
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT_TAG;
                end
            end
            ST_WAIT_TAG: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == WAIT_LAST) begin
                    // Go straight into the data frame. The grant stays held.
                    timer_d    = '0;
                    tx_start_d = 1'b1;
                    tx_data_d  = data_q;
                    state_d    = ST_START;
                end
            end
`endif
            ST_START: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == START_LAST) begin
                    timer_d    = '0;
                    tx_start_d = 1'b0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == WAIT_LAST) begin
                    timer_d = '0;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                timer_d    = '0;
                grant_d    = '0;
                tx_start_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
`ifdef UART_ARB_TAG_EN
            data_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
`ifdef UART_ARB_TAG_EN
            data_q     <= data_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign grant    = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed and randomized stimulus for uart_tx_arbiter with BAUD_DIV=8 and
// FRAME_BAUDS=12. A transaction-level model supplies the expected winners:
// the nearest pending request at or after the pointer, with the pointer
// becoming winner+1. A behavioural transmitter and a line decoder check the
// bytes that reach the serial line.
// Set UART_ARB_TAG_EN to check the two-frame tag mode.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N         = 4;
    localparam int BD        = 8;
    localparam int FB        = 12;
    localparam int FRAME_CYC = BD * (1 + FB);
`ifdef UART_ARB_TAG_EN
    localparam int NFR = 2;
`else
    localparam int NFR = 1;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           busy;
    logic           tx_start;
    logic [7:0]     tx_data;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (N),
        .BAUD_DIV    (BD),
        .FRAME_BAUDS (FB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .grant    (grant),
        .busy     (busy),
        .tx_start (tx_start),
        .tx_data  (tx_data)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr = 0;
    int exp_bytes [$];
    int rx_bytes  [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural transmitter. It has no busy output and loads on a baud
    // tick when idle and the start strobe is high.
    int         baud_cnt;
    logic       txd = 1'b1;
    logic       tx_active;
    logic [9:0] tx_sh;
    int         tx_bits;

    always @(posedge clk) begin
        if (reset) begin
            baud_cnt  <= 0;
            txd       <= 1'b1;
            tx_active <= 1'b0;
            tx_sh     <= '1;
            tx_bits   <= 0;
        end else begin
            baud_cnt <= (baud_cnt == BD - 1) ? 0 : baud_cnt + 1;
            if (baud_cnt == BD - 1) begin
                if (tx_active) begin
                    if (tx_bits == 0) begin
                        tx_active <= 1'b0;
                        txd       <= 1'b1;
                    end else begin
                        txd     <= tx_sh[0];
                        tx_sh   <= {1'b1, tx_sh[9:1]};
                        tx_bits <= tx_bits - 1;
                    end
                end else if (tx_start) begin
                    tx_active <= 1'b1;
                    tx_sh     <= {1'b1, tx_data, 1'b0};
                    tx_bits   <= 10;
                end
            end
        end
    end

    // Line decoder. It samples mid-bit. A bad stop bit is flagged as +256.
    logic [7:0] rx_byte;
    initial begin
        forever begin
            @(negedge txd);
            repeat (BD / 2) @(posedge clk);
            if (txd !== 1'b0) continue;
            rx_byte = 8'h00;
            for (int i = 0; i < 8; i++) begin
                repeat (BD) @(posedge clk);
                rx_byte[i] = txd;
            end
            repeat (BD) @(posedge clk);
            rx_bytes.push_back((txd === 1'b1) ? int'(rx_byte) : int'(rx_byte) + 256);
        end
    end

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("ack_timeout", {31'b0, ok}, 32'd1);
    endtask

    // One grant: arbitrate, then walk the whole busy window cycle by cycle.
    task automatic do_frame(input logic [N-1:0] set_mask, input bit drop,
                            input logic [N-1:0] add_early, input logic [N-1:0] add_late,
                            input string tag);
        bit         ok;
        int         w;
        int         c;
        int         bad;
        logic [7:0] d;
        logic [7:0] exp_d;
        logic       exp_start;
        logic [N-1:0] oh;
        req = req | set_mask;
        w = pick(req, model_ptr);
        if (w < 0) begin
            check({tag, "_no_request"}, 32'(req), 32'd1);
            return;
        end
        wait_ack(ok);
        if (!ok) return;
        oh = N'(1) << w;
        d  = req_data[8*w +: 8];
        check({tag, "_ack"}, 32'(ack), 32'(oh));
        model_ptr = (w + 1) % N;
`ifdef UART_ARB_TAG_EN
        exp_bytes.push_back(32'h30 + w);
`endif
        exp_bytes.push_back(int'(d));
        bad = 0;
        c   = 0;
        while (busy === 1'b1 && c < 3 * FRAME_CYC * NFR) begin
            exp_start = ((c % FRAME_CYC) < BD);
            exp_d     = (NFR == 2 && c < FRAME_CYC) ? 8'(8'h30 + w) : d;
            if (tx_start !== exp_start || tx_data !== exp_d || grant !== oh ||
                ack !== ((c == 0) ? oh : '0)) bad++;
            if (c == 0 && drop) req[w] = 1'b0;
            if (c == 10) req = req | add_early;
            if (c == 60) req = req | add_late;
            c++;
            @(negedge clk);
        end
        check({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        check({tag, "_busy_len"}, 32'(c), 32'(FRAME_CYC * NFR));
        check({tag, "_grant_clr"}, 32'(grant), 32'd0);
        $display("frame %s: requester %0d byte %02h busy %0d cycles", tag, w, d, c);
    endtask

    initial begin
        bit ok;
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request from requester 1.
        req_data[15:8] = 8'hA5;
        do_frame(4'b0010, 1'b1, '0, '0, "single");

        // Reset at cycle 3 of START aborts the frame and clears the pointer.
        req_data[7:0] = 8'h3C;
        req = req | 4'b0001;
        wait_ack(ok);
        check("mid_ack", 32'(ack), 32'b0001);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_tx_start", 32'(tx_start), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_grant", 32'(grant), 32'd0);
        reset     = 1'b0;
        req       = '0;
        model_ptr = 0;
        @(negedge clk);

        // All four held for five frames: 0,1,2,3 and then 0 again.
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int i = 0; i < 5; i++) begin
            do_frame(4'b1111, 1'b0, '0, '0, $sformatf("all%0d", i));
        end
        req = '0;

        // Requester 2 waits during a frame and requester 3 arrives late.
        do_frame(4'b0010, 1'b1, 4'b0100, 4'b1000, "late_a");
        do_frame('0, 1'b1, '0, '0, "late_b");
        check("late_b_ptr", 32'(model_ptr), 32'd3);
        do_frame('0, 1'b1, '0, '0, "late_c");

        // Alternating bit pattern on the serial line.
        req_data[31:24] = 8'h55;
        do_frame(4'b1000, 1'b1, '0, '0, "byte55");

        // Randomized masks, data, hold/drop and mid-frame arrivals.
        for (int i = 0; i < 16; i++) begin
            req_data = $urandom;
            do_frame(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     $sformatf("rnd%0d", i));
        end
        req = '0;

        // The last byte must clear the line, and nothing else may follow.
        repeat (BD * 16) @(negedge clk);
        check("line_count", 32'(rx_bytes.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < rx_bytes.size(); i++) begin
            check($sformatf("line_byte%0d", i), 32'(rx_bytes[i]), 32'(exp_bytes[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
